// File: rtl/rv32i_pkg.sv
// Shared encodings for the RV32I multicycle controller: opcodes, datapath
// select/ALU/immediate encodings, FSM state and trap-cause enums.
package rv32i_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
    S_EXEC_R, S_EXEC_I, S_ALUWB, S_BEQ, S_JAL, S_UPPER, S_TRAP
  } state_t;

  typedef enum logic [1:0] {
    TC_NONE    = 2'b00,
    TC_OPCODE  = 2'b01,
    TC_FUNCT   = 2'b10,
    TC_TIMEOUT = 2'b11
  } trap_cause_t;

  // Immediate format the DECODE cycle needs to form a branch/jump target.
  function automatic logic [2:0] imm_for_op(input logic [6:0] op);
    case (op)
      OP_STORE:         return IMM_S;
      OP_BRANCH:        return IMM_B;
      OP_JAL:           return IMM_J;
      OP_LUI, OP_AUIPC: return IMM_U;
      default:          return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/mc_alu_dec.sv
// ALU function decode for R-type and I-type ALU instructions: maps funct3
// (and funct7[5] for R-type) to an ALU operation and flags illegal encodings.
module mc_alu_dec
  import rv32i_pkg::*;
(
  input  logic [2:0] i_func3,
  input  logic       i_func7_5,
  input  logic       i_is_rtype,
  output logic [2:0] o_alu_control,
  output logic       o_funct_legal
);

  always_comb begin
    o_alu_control = ALU_ADD;
    o_funct_legal = 1'b1;
    case (i_func3)
      3'b000: if (i_is_rtype && i_func7_5) o_alu_control = ALU_SUB;
      3'b110: o_alu_control = ALU_OR;
      3'b111: o_alu_control = ALU_AND;
      default: o_funct_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB, drives the
// datapath selects and strobes, counts retired instructions and traps.
module multicycle_ctrl
  import rv32i_pkg::*;
#(
  parameter int INSTRET_W   = 32,
  parameter int MEM_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [6:0]           op_code,
  input  logic [2:0]           func3,
  input  logic [6:0]           func7,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 mem_write,
  output logic                 adr_src,
  output logic                 ir_write,
  output logic                 pc_write,
  output logic                 reg_write,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           result_src,
  output logic [2:0]           imm_type,
  output logic [2:0]           alu_control,
  output logic                 trap,
  output logic [1:0]           trap_cause,
  output logic [INSTRET_W-1:0] instret,
  output logic [3:0]           o_dbg_state
);

  localparam int TO_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

  state_t               r_state;
  state_t               w_next;
  trap_cause_t          w_next_cause;
  logic [TO_W-1:0]      r_to_cnt;
  logic [INSTRET_W-1:0] r_instret;
  logic [1:0]           r_cause;
  logic [2:0]           w_dec_alu;
  logic                 w_funct_legal;
  logic                 w_is_rtype;
  logic                 w_waiting;
  logic                 w_timeout;
  logic                 w_retire;
  logic                 w_unused_func7;

  assign w_is_rtype     = (op_code == OP_R);
  assign w_unused_func7 = ^{func7[6], func7[4:0]};

  mc_alu_dec u_alu_dec (
    .i_func3       (func3),
    .i_func7_5     (func7[5]),
    .i_is_rtype    (w_is_rtype),
    .o_alu_control (w_dec_alu),
    .o_funct_legal (w_funct_legal)
  );

  // Memory handshake: a request completes in the cycle where mem_req and
  // mem_ready are both high; mem_req stays high until then (or a timeout trap).
  assign w_waiting = mem_req && !mem_ready;
  assign w_timeout = (MEM_TIMEOUT != 0) && w_waiting &&
                     (r_to_cnt == TO_W'(MEM_TIMEOUT - 1));

  always_comb begin
    w_next       = r_state;
    w_next_cause = TC_NONE;
    case (r_state)
      S_FETCH: if (mem_ready) w_next = S_DECODE;
      S_DECODE: begin
        case (op_code)
          OP_LOAD, OP_STORE: w_next = S_MEMADR;
          OP_R, OP_I: begin
            if (!w_funct_legal) begin
              w_next       = S_TRAP;
              w_next_cause = TC_FUNCT;
            end else begin
              w_next = w_is_rtype ? S_EXEC_R : S_EXEC_I;
            end
          end
          OP_BRANCH:        w_next = S_BEQ;
          OP_JAL:           w_next = S_JAL;
          OP_LUI, OP_AUIPC: w_next = S_UPPER;
          default: begin
            w_next       = S_TRAP;
            w_next_cause = TC_OPCODE;
          end
        endcase
      end
      S_MEMADR:   w_next = op_code[5] ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (mem_ready) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (mem_ready) w_next = S_FETCH;
      S_EXEC_R, S_EXEC_I, S_JAL, S_UPPER: w_next = S_ALUWB;
      S_ALUWB, S_BEQ: w_next = S_FETCH;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
    if (w_timeout) begin
      w_next       = S_TRAP;
      w_next_cause = TC_TIMEOUT;
    end
  end

  assign w_retire = (w_next == S_FETCH) &&
                    (r_state == S_MEMWB || r_state == S_MEMWRITE ||
                     r_state == S_ALUWB || r_state == S_BEQ);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_FETCH;
      r_instret <= '0;
      r_cause   <= TC_NONE;
      r_to_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_instret <= r_instret + INSTRET_W'(1);
      if (r_state != S_TRAP && w_next == S_TRAP) r_cause <= w_next_cause;
      // Any state change is an entry into a fresh wait window.
      if (w_next != r_state) r_to_cnt <= '0;
      else if (w_waiting)    r_to_cnt <= r_to_cnt + TO_W'(1);
    end
  end

  always_comb begin
    mem_req     = 1'b0;
    mem_write   = 1'b0;
    adr_src     = 1'b0;
    ir_write    = 1'b0;
    pc_write    = 1'b0;
    reg_write   = 1'b0;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    result_src  = RES_ALUOUT;
    imm_type    = IMM_I;
    alu_control = ALU_ADD;
    case (r_state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        imm_type  = imm_for_op(op_code);
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
        imm_type  = op_code[5] ? IMM_S : IMM_I;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
      end
      S_MEMWB: begin
        result_src = RES_MEM;
        reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a   = SRCA_RS1;
        alu_control = w_dec_alu;
      end
      S_EXEC_I: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = w_dec_alu;
      end
      S_ALUWB: reg_write = 1'b1;
      S_BEQ: begin
        alu_src_a   = SRCA_RS1;
        alu_control = ALU_SUB;
        pc_write    = zero;
      end
      S_JAL: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_FOUR;
        pc_write  = 1'b1;
      end
      S_UPPER: begin
        imm_type  = IMM_U;
        alu_src_b = SRCB_IMM;
        alu_src_a = op_code[5] ? SRCA_ZERO : SRCA_OLDPC;
      end
      default: ;
    endcase
    // Strobes and selects are forced low combinationally while reset is held.
    if (!rst_n) begin
      mem_req     = 1'b0;
      mem_write   = 1'b0;
      adr_src     = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      reg_write   = 1'b0;
      alu_src_a   = 2'b00;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      imm_type    = 3'b000;
      alu_control = 3'b000;
    end
  end

  assign trap        = (r_state == S_TRAP);
  assign trap_cause  = r_cause;
  assign instret     = r_instret;
  assign o_dbg_state = r_state;

endmodule
